pipe_ctrl: RTL and testbench

- Central hazard and sequencing controller for the 5-stage RV64 pipeline.
- Owns the valid bit of each inter-stage register (if_id, id_ex, ex_mem, mem_wb).
- Generates the load enables and bubble/flush decisions for those registers and for the PC.
- Resolves data-memory back-pressure, load-use hazards and EX-stage redirects.
- Keeps saturating retire and stall counters for the difftest/perf path.

---
 rtl/pipe_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the 5-stage RV64 pipeline.
//
// Owns the valid bits of the if_id, id_ex, ex_mem and mem_wb registers.
// Decides per cycle between four mutually exclusive cases, in priority order:
// dmem back-pressure, EX redirect, load-use hazard, normal flow. It drives
// the PC and pipeline-register load enables from that decision.
// It also keeps saturating retire and stall counters.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   fetch_valid            imem response valid for the IF stage
//   id_rs1_addr/rs2_addr   source registers of the instruction in if_id
//   id_uses_rs1/rs2        the ID instruction actually reads rs1/rs2
//   ex_is_load, ex_rd_addr load flag and destination of the id_ex instruction
//   ex_redirect            EX resolved a taken branch/jump
//   mem_busy               dmem access outstanding in MEM
//   pc_en, pc_sel_redirect PC load enable and target select
//   *_en                   pipeline register load enables
//   *_valid                registered stage valid bits
//   retire_cnt, stall_cnt  saturating perf counters
//
// Case encoding (combinational decode, no stored state):
//   case        | meaning
//   NORMAL      | everything advances; fetch_valid decides the IF bubble
//   LOAD_USE    | hold PC and if_id, inject one bubble into id_ex
//   REDIRECT    | load EX target into PC, squash if_id and id_ex
//   MEM_STALL   | freeze the front three stages, send a bubble to WB

module pipe_ctrl #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              pc_sel_redirect,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_valid,
  output logic              id_ex_valid,
  output logic              ex_mem_valid,
  output logic              mem_wb_valid,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] CASE_NORMAL    = 2'd0;
  localparam logic [1:0] CASE_LOAD_USE  = 2'd1;
  localparam logic [1:0] CASE_REDIRECT  = 2'd2;
  localparam logic [1:0] CASE_MEM_STALL = 2'd3;

  logic       redirect;
  logic       load_use;
  logic       rs1_hit;
  logic       rs2_hit;
  logic [1:0] cur_case;

  // A redirect from a bubble in id_ex is stale and must be ignored.
  assign redirect = ex_redirect && id_ex_valid;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign rs1_hit  = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  assign load_use = id_ex_valid && ex_is_load && (ex_rd_addr != '0) &&
                    if_id_valid && (rs1_hit || rs2_hit);

  always_comb begin
    cur_case = CASE_NORMAL;
    if (mem_busy)      cur_case = CASE_MEM_STALL;
    else if (redirect) cur_case = CASE_REDIRECT;
    else if (load_use) cur_case = CASE_LOAD_USE;
  end

  always_comb begin
    pc_en           = fetch_valid;
    pc_sel_redirect = 1'b0;
    if_id_en        = 1'b1;
    id_ex_en        = 1'b1;
    ex_mem_en       = 1'b1;
    // WB always loads: it either advances or takes a bubble.
    mem_wb_en       = 1'b1;
    case (cur_case)
      CASE_MEM_STALL: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
      end
      CASE_REDIRECT: begin
        pc_en           = 1'b1;
        pc_sel_redirect = 1'b1;
      end
      CASE_LOAD_USE: begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_valid  <= 1'b0;
      id_ex_valid  <= 1'b0;
      ex_mem_valid <= 1'b0;
      mem_wb_valid <= 1'b0;
      retire_cnt   <= '0;
      stall_cnt    <= '0;
    end else begin
      case (cur_case)
        CASE_MEM_STALL: begin
          mem_wb_valid <= 1'b0;
        end
        CASE_REDIRECT: begin
          if_id_valid  <= 1'b0;
          id_ex_valid  <= 1'b0;
          ex_mem_valid <= id_ex_valid;
          mem_wb_valid <= ex_mem_valid;
        end
        CASE_LOAD_USE: begin
          id_ex_valid  <= 1'b0;
          ex_mem_valid <= id_ex_valid;
          mem_wb_valid <= ex_mem_valid;
        end
        default: begin
          if_id_valid  <= fetch_valid;
          id_ex_valid  <= if_id_valid;
          ex_mem_valid <= id_ex_valid;
          mem_wb_valid <= ex_mem_valid;
        end
      endcase

      if (mem_wb_valid && (retire_cnt != '1))
        retire_cnt <= retire_cnt + CNT_W'(1);
      if (!pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. A 32-bit counter instance carries the
// functional checks; a CNT_W=4 instance shares its inputs to exercise
// counter saturation.

module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_valid;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect, mem_busy;

  logic        pc_en, pc_sel_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid;
  logic [31:0] retire_cnt, stall_cnt;

  logic       pc_en4, pc_sel4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4;
  logic       if_id_v4, id_ex_v4, ex_mem_v4, mem_wb_v4;
  logic [3:0] retire4, stall4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32), .REG_AW(5)) u_dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en), .pc_sel_redirect(pc_sel_redirect),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_valid(if_id_valid), .id_ex_valid(id_ex_valid),
    .ex_mem_valid(ex_mem_valid), .mem_wb_valid(mem_wb_valid),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.CNT_W(4), .REG_AW(5)) u_dut4 (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(pc_en4), .pc_sel_redirect(pc_sel4),
    .if_id_en(if_id_en4), .id_ex_en(id_ex_en4), .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
    .if_id_valid(if_id_v4), .id_ex_valid(id_ex_v4),
    .ex_mem_valid(ex_mem_v4), .mem_wb_valid(mem_wb_v4),
    .retire_cnt(retire4), .stall_cnt(stall4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle_in();
    fetch_valid = 1'b0;
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_is_load = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  // Advance one rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packs valids as {if_id, id_ex, ex_mem, mem_wb}.
  function automatic logic [31:0] vbits();
    return {28'd0, if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid};
  endfunction

  function automatic logic [31:0] enbits();
    return {26'd0, pc_en, pc_sel_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  endfunction

  initial begin
    idle_in();
    reset = 1'b1;
    step();
    step();
    chk("reset_valids", vbits(), 32'h0);
    chk("reset_retire", retire_cnt, 32'd0);
    chk("reset_stall", stall_cnt, 32'd0);

    // Fill: pipeline fills one stage per edge; mem_wb valid after the 4th edge.
    reset = 1'b0;
    fetch_valid = 1'b1;
    #1;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 1) chk("fill_e1_valids", vbits(), 32'b1000);
      if (i == 3) chk("fill_e3_memwb", {31'd0, mem_wb_valid}, 32'd0);
      if (i == 4) chk("fill_e4_memwb", {31'd0, mem_wb_valid}, 32'd1);
    end
    // mem_wb was 1 before edges 5..11 -> 7 retirements.
    chk("fill_retire", retire_cnt, 32'd7);
    chk("fill_stall", stall_cnt, 32'd0);
    chk("fill_valids", vbits(), 32'b1111);

    // Load-use: load to x5 in EX, ID reads rs1=x5.
    ex_is_load = 1'b1; ex_rd_addr = 5'd5;
    id_uses_rs1 = 1'b1; id_rs1_addr = 5'd5;
    #1;
    // {pc_en, sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}
    chk("lu_enables", enbits(), 32'b000111);
    step();
    chk("lu_valids", vbits(), 32'b1011);
    chk("lu_stall", stall_cnt, 32'd1);
    chk("lu_retire", retire_cnt, 32'd8);
    chk("lu_next_pc_en", {31'd0, pc_en}, 32'd1);
    step();
    chk("lu_after_valids", vbits(), 32'b1101);
    chk("lu_after_retire", retire_cnt, 32'd9);
    chk("lu_after_stall", stall_cnt, 32'd1);
    // rd = x0 never stalls.
    ex_rd_addr = 5'd0; id_rs1_addr = 5'd0;
    #1;
    chk("lu_x0_pc_en", {31'd0, pc_en}, 32'd1);
    // Match ignored when rs1 is not used.
    ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b0;
    #1;
    chk("lu_nouse_pc_en", {31'd0, pc_en}, 32'd1);
    // rs2 path does stall.
    id_uses_rs2 = 1'b1; id_rs2_addr = 5'd5;
    #1;
    chk("lu_rs2_pc_en", {31'd0, pc_en}, 32'd0);

    // Redirect beats the simultaneous load-use hazard.
    ex_redirect = 1'b1;
    #1;
    chk("rd_enables", enbits(), 32'b111111);
    step();
    chk("rd_valids", vbits(), 32'b0010);
    chk("rd_retire", retire_cnt, 32'd10);
    chk("rd_stall", stall_cnt, 32'd1);
    // id_ex now holds a bubble, so the still-high ex_redirect is ignored.
    chk("rd_stale_sel", {31'd0, pc_sel_redirect}, 32'd0);

    // Refill to {1,1,1,0} for the busy test.
    idle_in();
    fetch_valid = 1'b1;
    step();   // 1001, retire 10
    step();   // 1100, retire 11
    step();   // 1110, retire 11
    chk("pre_busy_valids", vbits(), 32'b1110);
    chk("pre_busy_retire", retire_cnt, 32'd11);

    // mem_busy for 3 cycles with a pending redirect.
    mem_busy = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_enables", enbits(), 32'b000001);
      step();
      chk("busy_valids", vbits(), 32'b1110);
    end
    chk("busy_stall", stall_cnt, 32'd4);
    chk("busy_retire", retire_cnt, 32'd11);
    mem_busy = 1'b0;
    #1;
    chk("busy_release_en", enbits(), 32'b111111);
    step();
    chk("busy_release_valids", vbits(), 32'b0011);
    chk("busy_release_stall", stall_cnt, 32'd4);

    // Fetch toggling from a clean pipe.
    idle_in();
    reset = 1'b1;
    step();
    reset = 1'b0;
    fetch_valid = 1'b1; step();   // 1000
    fetch_valid = 1'b0; step();   // 0100, stall 1
    fetch_valid = 1'b1; step();   // 1010
    fetch_valid = 1'b0; step();   // 0101, stall 2
    chk("tog_valids", vbits(), 32'b0101);
    chk("tog_stall", stall_cnt, 32'd2);
    step();                       // 0010, retire 1
    chk("tog_bubble_valids", vbits(), 32'b0010);
    step();                       // 0001
    step();                       // 0000, retire 2
    step();
    chk("tog_retire", retire_cnt, 32'd2);
    chk("tog_stall_end", stall_cnt, 32'd6);

    // Reset during a mem_busy stall with all valids set.
    fetch_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rst_pre_valids", vbits(), 32'b1111);
    mem_busy = 1'b1;
    reset = 1'b1;
    step();
    chk("rst_busy_valids", vbits(), 32'h0);
    chk("rst_busy_retire", retire_cnt, 32'd0);
    step();
    chk("rst_busy_stall", stall_cnt, 32'd0);

    // Saturation on the 4-bit instance.
    mem_busy = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 25; i++) step();
    chk("sat_retire32", retire_cnt, 32'd21);
    chk("sat_retire4", {28'd0, retire4}, 32'd15);
    fetch_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall32", stall_cnt, 32'd20);
    chk("sat_stall4", {28'd0, stall4}, 32'd15);
    chk("sat_retire4_hold", {28'd0, retire4}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
